// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared FSM encoding and default stability window for the switch debouncer.
package sw_debounce_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
endpackage

// File: rtl/sw_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer bank with a configurable reset value.
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: whole-word DIP switch debouncer with change strobe, sticky flag and CPU read word.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             chg_pulse,
  output logic             sw_changed,
  input  logic             rd_ack,
  output logic [31:0]      rdata
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic             changed_q, changed_d, commit;
  sync_2ff #(.W(WIDTH), .RST_VAL(RESET_VAL)) u_sync (
    .clk(clk), .reset(reset), .d(sw_raw), .q(sync)
  );
  // stable word loads on the edge entering COMMIT so the strobe cycle already shows it
  assign commit = state_q == ST_COUNT && sync != stable_q && sync == cand_q && cnt_q == CNT_MAX;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    stable_d  = stable_q;
    changed_d = commit | (changed_q & ~rd_ack);
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync != stable_q) begin
          cand_d  = sync;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sync == stable_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sync != cand_q) begin
          cand_d = sync;
          cnt_d  = '0;
        end else if (commit) begin
          stable_d = cand_q;
          cnt_d    = '0;
          state_d  = ST_COMMIT;
        end else
          cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cand_q    <= RESET_VAL;
      stable_q  <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  assign sw_stable  = stable_q;
  assign chg_pulse  = state_q == ST_COMMIT;
  assign sw_changed = changed_q;
  assign rdata      = 32'({changed_q, stable_q});
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed vector table plus hand-written corner sequences for sw_debounce.
module tb_sw_debounce;
  import sw_debounce_pkg::*;
  logic        clk, reset, rd_ack, chg_pulse, sw_changed;
  logic [7:0]  sw_raw, sw_stable;
  logic [31:0] rdata;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [7:0]  raw;
    logic        ack;
    logic [7:0]  stable;
    logic        pulse;
    logic        changed;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[10];
  sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .chg_pulse(chg_pulse), .sw_changed(sw_changed), .rd_ack(rd_ack), .rdata(rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input logic [7:0] st, input logic p, input logic c, input logic [31:0] rd);
    chk({name, ".stable"}, 32'(sw_stable), 32'(st));
    chk({name, ".pulse"}, 32'(chg_pulse), 32'(p));
    chk({name, ".changed"}, 32'(sw_changed), 32'(c));
    chk({name, ".rdata"}, rdata, rd);
  endtask
  task automatic do_reset(input logic [7:0] raw);
    sw_raw = raw;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  // new value must appear on the 7th edge after sw_raw changes (2 sync + 4 window + 1)
  task automatic run_change(input string name, input logic [7:0] raw, input logic [7:0] old_val);
    sw_raw = raw;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk({name, ".hold_stable"}, 32'(sw_stable), 32'(old_val));
      chk({name, ".hold_pulse"}, 32'(chg_pulse), 32'h0);
    end
    tick();
    chk({name, ".commit_stable"}, 32'(sw_stable), 32'(raw));
    chk({name, ".commit_pulse"}, 32'(chg_pulse), 32'h1);
    tick();
    chk({name, ".pulse_drop"}, 32'(chg_pulse), 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 6; i++) tbl[i] = '{8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 32'h1A5};
    tbl[7] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 32'h1A5};
    tbl[8] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 32'h0A5};
    tbl[9] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 32'h0A5};
    rd_ack = 1'b0;
    sw_raw = 8'hFF;
    reset  = 1'b1;
    #3;
    chk_all("reset_async", 8'h00, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_all("reset_held", 8'h00, 1'b0, 1'b0, 32'h0);
    sw_raw = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_all("idle_quiet", 8'h00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      sw_raw = tbl[i].raw;
      rd_ack = tbl[i].ack;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].stable, tbl[i].pulse, tbl[i].changed, tbl[i].rdata);
    end
    rd_ack = 1'b0;
    do_reset(8'h00);
    chk_all("reset2", 8'h00, 1'b0, 1'b0, 32'h0);
    for (int t = 0; t < 4; t++) begin
      sw_raw = t[0] ? 8'h00 : 8'h01;
      for (int k = 0; k < 2; k++) begin
        tick();
        chk("bounce.stable", 32'(sw_stable), 32'h0);
        chk("bounce.pulse", 32'(chg_pulse), 32'h0);
      end
    end
    run_change("bounce_final", 8'h01, 8'h00);
    chk("bounce.rdata", rdata, 32'h101);
    sw_raw = 8'h0F;
    for (int i = 0; i < 3; i++) tick();
    run_change("recapture", 8'hF0, 8'h01);
    do_reset(8'h00);
    chk_all("reset3", 8'h00, 1'b0, 1'b0, 32'h0);
    sw_raw = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midcount.pulse", 32'(chg_pulse), 32'h0);
    end
    reset = 1'b1;
    #1;
    chk_all("midcount.reset", 8'h00, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_all("midcount.held", 8'h00, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    run_change("after_reset", 8'h3C, 8'h00);
    chk("after_reset.rdata", rdata, 32'h13C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
